// File: rtl/coax_pkg.sv
// Shared coax definitions: word width, sequencer state encodings, common command words.
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef logic [COAX_WORD_WIDTH-1:0] coax_word_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_FETCH = 3'd1,
        SEQ_LOAD  = 3'd2,
        SEQ_WAIT  = 3'd3,
        SEQ_PAUSE = 3'd4
    } seq_state_t;

    // Common coax command words
    localparam coax_word_t WRITE_DATA = 10'b0000110001;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coax_msg_buffer.sv
// Message buffer: DEPTH x word simple dual-port RAM, synchronous write,
// synchronous read-before-write. The read register is cleared by reset so the
// sequencer's tx_data starts at zero; the array itself keeps its contents.
module coax_msg_buffer #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port; no reset so stored messages survive a sequencer reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Read port; same-edge write to the same address returns the old word
    always_ff @(posedge clk) begin
        if (reset)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/coax_tx_sequencer.sv
// Plays a buffered sequence of coax words into coax_tx, one word per transmit
// slot, with fixed load window, minimum word spacing and optional repeat.
module coax_tx_sequencer
    import coax_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int LOAD_CYCLES = 8,
    parameter int GAP_CYCLES  = 33,
    parameter int REPEAT_GAP  = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [COAX_WORD_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH:0]        length,
    input  logic                       start,
    input  logic                       repeat_en,
    input  logic                       abort,
    output logic                       tx_load,
    output logic [COAX_WORD_WIDTH-1:0] tx_data,
    input  logic                       tx_full,
    output logic                       busy,
    output logic                       done
);

    localparam int CNT_W = $clog2(max_int(GAP_CYCLES, REPEAT_GAP) + 1);

    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]    LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]    REP_LAST  = CNT_W'(REPEAT_GAP - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LEN_ONE   = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = 1;

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH:0]   len;
    logic                  rep;
    logic                  abort_seen;
    logic [CNT_W-1:0]      cnt;
    logic                  last_word;

    assign last_word = ({1'b0, idx} + LEN_ONE) >= len;

    // The buffer's read register is the registered tx_data output
    coax_msg_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (COAX_WORD_WIDTH)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (state == SEQ_FETCH),
        .rd_addr (idx),
        .rd_data (tx_data)
    );

    // Sequencer FSM with slot/pause counter and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEQ_IDLE;
            idx        <= '0;
            len        <= '0;
            rep        <= 1'b0;
            abort_seen <= 1'b0;
            cnt        <= '0;
            tx_load    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start && length != '0) begin
                        len        <= (length > DEPTH_L) ? DEPTH_L : length;
                        rep        <= repeat_en;
                        idx        <= '0;
                        abort_seen <= 1'b0;
                        busy       <= 1'b1;
                        state      <= SEQ_FETCH;
                    end
                end
                SEQ_FETCH: begin
                    if (abort) abort_seen <= 1'b1;
                    cnt     <= '0;
                    tx_load <= 1'b1;
                    state   <= SEQ_LOAD;
                end
                SEQ_LOAD: begin
                    if (abort) abort_seen <= 1'b1;
                    cnt <= cnt + CNT_ONE;
                    if (cnt == LOAD_LAST) begin
                        tx_load <= 1'b0;
                        state   <= SEQ_WAIT;
                    end
                end
                SEQ_WAIT: begin
                    if (abort) abort_seen <= 1'b1;
                    // saturate so a long tx_full stall never wraps back below GAP_LAST
                    if (cnt != CNT_MAX) cnt <= cnt + CNT_ONE;
                    if (cnt >= GAP_LAST && !tx_full) begin
                        if (abort_seen || abort || (last_word && !rep)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= SEQ_IDLE;
                        end else if (!last_word) begin
                            idx   <= idx + IDX_ONE;
                            state <= SEQ_FETCH;
                        end else begin
                            cnt   <= '0;
                            state <= SEQ_PAUSE;
                        end
                    end
                end
                SEQ_PAUSE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= SEQ_IDLE;
                    end else if (cnt == REP_LAST) begin
                        idx   <= '0;
                        state <= SEQ_FETCH;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coax_tx_sequencer.sv
// Scoreboard bench for coax_tx_sequencer: stimulus pushes expected
// (word, first-load cycle) pairs, a negedge monitor pops and compares on each
// rising tx_load and checks load window length and done/busy exclusivity.
module tb_coax_tx_sequencer;
    import coax_pkg::*;

    localparam int AW = 4;
    localparam int LC = 8;
    localparam int GC = 33;
    localparam int RG = 1000;
    localparam int PER = GC + 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [9:0]      wr_data = '0;
    logic [AW:0]     length = '0;
    logic            start = 1'b0;
    logic            repeat_en = 1'b0;
    logic            abort = 1'b0;
    logic            tx_load;
    logic [9:0]      tx_data;
    logic            tx_full = 1'b0;
    logic            busy;
    logic            done;

    coax_tx_sequencer #(
        .ADDR_WIDTH (AW),
        .LOAD_CYCLES(LC),
        .GAP_CYCLES (GC),
        .REPEAT_GAP (RG)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .length    (length),
        .start     (start),
        .repeat_en (repeat_en),
        .abort     (abort),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .tx_full   (tx_full),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0] w;
        int         c;
    } exp_t;

    exp_t       q[$];
    logic [9:0] mdl [16];
    int         errors = 0;
    int         checks = 0;
    int         done_cnt = 0;
    int         run = 0;
    bit         prev_load = 1'b0;
    bit         skip_len = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compare each new load window against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (tx_load && !prev_load) begin
                if (q.size() == 0) begin
                    chk(1'b0, "unexpected_load", int'(tx_data), -1);
                end else begin
                    e = q.pop_front();
                    chk(tx_data == e.w, "load_data", int'(tx_data), int'(e.w));
                    chk(cyc == e.c, "load_cycle", cyc, e.c);
                end
            end
            if (!tx_load && prev_load && !skip_len)
                chk(run == LC, "load_len", run, LC);
            if (done) begin
                done_cnt++;
                chk(!busy, "done_busy", int'(busy), 0);
            end
        end
        run = tx_load ? (prev_load ? run + 1 : 1) : 0;
        prev_load = tx_load;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [9:0] d);
        wr_addr = AW'(a);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        mdl[a]  = d;
    endtask

    task automatic go(input int l, input bit r, output int s);
        length    = (AW+1)'(l);
        repeat_en = r;
        s         = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic push(input logic [9:0] w, input int c);
        exp_t e;
        e.w = w;
        e.c = c;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick();
            n++;
        end
        chk(!busy, name, int'(busy), 0);
        tick();
        tick();
    endtask

    initial begin
        int s;
        logic [9:0] old1;
        logic [9:0] hello [6];
        hello[0] = WRITE_DATA;
        hello[1] = 10'h048;
        hello[2] = 10'h065;
        hello[3] = 10'h06C;
        hello[4] = 10'h06C;
        hello[5] = 10'h06F;

        // reset state
        repeat (3) tick();
        chk(tx_load == 1'b0, "rst_tx_load", int'(tx_load), 0);
        chk(tx_data == 10'd0, "rst_tx_data", int'(tx_data), 0);
        chk(busy == 1'b0, "rst_busy", int'(busy), 0);
        chk(done == 1'b0, "rst_done", int'(done), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) wr(i, hello[i]);
        for (int i = 6; i < 16; i++) wr(i, 10'(10'h100 + i * 7));

        // basic six-word message
        go(6, 1'b0, s);
        for (int k = 0; k < 6; k++) push(mdl[k], s + 2 + PER * k);
        wait_idle("t1_idle", 1000);
        chk(done_cnt == 1, "t1_done", done_cnt, 1);
        chk(q.size() == 0, "t1_drain", q.size(), 0);

        // tx_full stall during word index 2 WAIT
        go(6, 1'b0, s);
        for (int k = 0; k < 3; k++) push(mdl[k], s + 2 + PER * k);
        for (int k = 3; k < 6; k++) push(mdl[k], s + 182 + PER * (k - 3));
        wait_cyc(s + 80);
        tx_full = 1'b1;
        wait_cyc(s + 180);
        tx_full = 1'b0;
        wait_idle("t2_idle", 1000);
        chk(done_cnt == 2, "t2_done", done_cnt, 2);
        chk(q.size() == 0, "t2_drain", q.size(), 0);

        // zero length is ignored
        go(0, 1'b0, s);
        for (int i = 0; i < 10; i++) begin
            chk(!busy, "len0_busy", int'(busy), 0);
            tick();
        end
        chk(done_cnt == 2, "len0_done", done_cnt, 2);

        // oversize length clamps to the 16-word depth
        go(31, 1'b0, s);
        for (int k = 0; k < 16; k++) push(mdl[k], s + 2 + PER * k);
        wait_idle("clamp_idle", 1000);
        chk(done_cnt == 3, "clamp_done", done_cnt, 3);
        chk(q.size() == 0, "clamp_drain", q.size(), 0);

        // repeat mode, abort during second pass word B load
        go(2, 1'b1, s);
        push(mdl[0], s + 2);
        push(mdl[1], s + 2 + PER);
        push(mdl[0], s + 2 + PER + GC + RG + 1);
        push(mdl[1], s + 2 + 2 * PER + GC + RG + 1);
        wait_cyc(s + 1107);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_idle("rep_idle", 200);
        chk(done_cnt == 4, "rep_done", done_cnt, 4);
        repeat (60) tick();
        chk(q.size() == 0, "rep_drain", q.size(), 0);

        // abort inside PAUSE ends on the next cycle
        go(1, 1'b1, s);
        push(mdl[0], s + 2);
        wait_cyc(s + 100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk(!busy, "pause_abort_busy", int'(busy), 0);
        tick();
        chk(done_cnt == 5, "pause_abort_done", done_cnt, 5);

        // writes while busy: later address sees new word, same-cycle FETCH sees old
        old1 = mdl[1];
        go(4, 1'b0, s);
        push(mdl[0], s + 2);
        push(old1, s + 2 + PER);
        push(10'h2A5, s + 2 + 2 * PER);
        push(mdl[3], s + 2 + 3 * PER);
        wait_cyc(s + 15);
        wr(2, 10'h2A5);
        wait_cyc(s + 1 + PER);
        wr(1, 10'h15A);
        wait_idle("wr_idle", 1000);
        chk(done_cnt == 6, "wr_done", done_cnt, 6);
        chk(q.size() == 0, "wr_drain", q.size(), 0);

        // reset mid-load of word index 2
        go(4, 1'b0, s);
        for (int k = 0; k < 3; k++) push(mdl[k], s + 2 + PER * k);
        wait_cyc(s + 72);
        skip_len = 1'b1;
        reset = 1'b1;
        tick();
        chk(tx_load == 1'b0, "mid_rst_load", int'(tx_load), 0);
        chk(tx_data == 10'd0, "mid_rst_data", int'(tx_data), 0);
        chk(busy == 1'b0, "mid_rst_busy", int'(busy), 0);
        chk(done == 1'b0, "mid_rst_done", int'(done), 0);
        reset = 1'b0;
        tick();
        tick();
        skip_len = 1'b0;
        chk(done_cnt == 6, "mid_rst_nodone", done_cnt, 6);
        chk(q.size() == 0, "mid_rst_drain", q.size(), 0);

        // fresh start replays from word 0 with preserved buffer
        go(3, 1'b0, s);
        for (int k = 0; k < 3; k++) push(mdl[k], s + 2 + PER * k);
        wait_idle("replay_idle", 1000);
        chk(done_cnt == 7, "replay_done", done_cnt, 7);
        chk(q.size() == 0, "replay_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
